// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : trace_pkg                                                 |
// | Purpose  : Shared constants, register order and FSM state type for   |
// |            the trace frame streamer.                                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam logic [7:0] FRAME_MAGIC    = 8'hA5;
  localparam int         FRAME_WORDS    = 20;
  localparam int         NUM_TRACE_REGS = 18;

  // Architectural register numbers in frame order: $s0-$s7, $t0-$t7, $t8, $t9
  localparam logic [4:0] ORDER [NUM_TRACE_REGS] = '{
    5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
    5'd24, 5'd25
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PCW  = 2'd2,
    REGS = 2'd3
  } state_t;

  // Register number for a frame slot; slots past the end fold back to slot 0
  function automatic logic [4:0] order_addr(input logic [4:0] slot);
    logic [4:0] addr;
    addr = ORDER[0];
    if (slot < 5'(NUM_TRACE_REGS)) addr = ORDER[slot];
    return addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : trace_out_reg                                             |
// | Purpose  : Stream output holding register. A load presents a new     |
// |            word; a clear retires the last word. Otherwise the word   |
// |            and its flags hold, which keeps them stable under stall.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module trace_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              clear,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // Hold the presented word until the controller loads the next one or clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (clear) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : trace_frame_streamer                                      |
// | Purpose  : Stalls the CPU after a committed cycle and streams one     |
// |            20-word trace frame (header, PC, 18 registers) over a     |
// |            valid/ready interface. Counts requests that arrive busy.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module trace_frame_streamer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap_req,
  input  logic [DATA_W-1:0] pc_in,
  output logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_TRACE_REGS);

  state_t            state;
  logic [4:0]        idx;
  logic [15:0]       seq;
  logic [DATA_W-1:0] pc_q;

  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              clear;

  assign accept = out_valid & out_ready;

  // Choose the next word to present: header on request, then PC, then registers
  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          load      = 1'b1;
          load_data = DATA_W'({FRAME_MAGIC, 8'(FRAME_WORDS), seq});
        end
      end
      HDR: begin
        if (accept) begin
          load      = 1'b1;
          load_data = pc_q;
        end
      end
      PCW: begin
        if (accept) begin
          load      = 1'b1;
          load_data = rd_data;
        end
      end
      REGS: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            clear = 1'b1;
          end else begin
            load      = 1'b1;
            load_data = rd_data;
            load_last = (idx == LAST_IDX - 5'd1);
          end
        end
      end
      default: ;
    endcase
  end

  // Frame sequencing; rd_addr is registered one slot ahead so it never depends on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      seq     <= '0;
      pc_q    <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            state   <= HDR;
            busy    <= 1'b1;
            pc_q    <= pc_in;
            seq     <= seq + 16'd1;
            idx     <= '0;
            rd_addr <= order_addr(5'd0);
          end
        end
        HDR: begin
          if (accept) state <= PCW;
        end
        PCW: begin
          if (accept) begin
            state   <= REGS;
            idx     <= 5'd1;
            rd_addr <= order_addr(5'd1);
          end
        end
        REGS: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              state   <= IDLE;
              busy    <= 1'b0;
              idx     <= '0;
              rd_addr <= order_addr(5'd0);
            end else begin
              idx     <= idx + 5'd1;
              rd_addr <= order_addr(idx + 5'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Count snapshot requests that arrive while a frame is in flight, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (snap_req && (state != IDLE) && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  trace_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .clear     (clear),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_trace_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_trace_frame_streamer                                   |
// | Purpose  : Self-checking bench for trace_frame_streamer against a    |
// |            queue-based frame model, plus literal frame expectations. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_trace_frame_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snap_req = 1'b0;
  logic [31:0] pc_in = '0;
  logic        out_ready = 1'b1;

  logic [4:0]  rd_addr, rd_addr2;
  logic [31:0] rd_data, rd_data2;
  logic        busy, busy2, out_valid, out_valid2, out_last, out_last2;
  logic [31:0] out_data, out_data2;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt2;

  logic [31:0] regs [32];
  assign rd_data  = regs[rd_addr];
  assign rd_data2 = regs[rd_addr2];

  always #5 clk = ~clk;

  trace_frame_streamer #(.DATA_W(32), .DROP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .pc_in(pc_in),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .drop_cnt(drop_cnt)
  );

  trace_frame_streamer #(.DATA_W(32), .DROP_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .snap_req(snap_req), .pc_in(pc_in),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2), .drop_cnt(drop_cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural frame model ----------------
  int          ord [18] = '{16, 17, 18, 19, 20, 21, 22, 23, 8, 9, 10, 11, 12, 13, 14, 15, 24, 25};
  logic [31:0] m_q [$];
  bit          m_active = 0;
  int          m_seq = 0;
  int          m_drops = 0;

  // A frame is the 20 words fixed at request time; it ends when the last one is taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      m_q.delete();
      m_seq = 0;
      m_drops = 0;
    end else if (m_active) begin
      if (snap_req) m_drops++;
      if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_active = 0;
      end
    end else if (snap_req) begin
      m_q.push_back({8'hA5, 8'd20, 16'(m_seq)});
      m_q.push_back(pc_in);
      for (int k = 0; k < 18; k++) m_q.push_back(regs[ord[k]]);
      m_seq = (m_seq + 1) % 65536;
      m_active = 1;
    end
  end

  logic [31:0] got [$];
  int          busy_cycles = 0;

  // Compare both DUTs with the model mid-cycle and log accepted words
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_active);
      check("valid", out_valid, m_active);
      check("busy2", busy2, m_active);
      check("valid2", out_valid2, m_active);
      if (m_active) begin
        check("data", out_data, m_q[0]);
        check("last", out_last, m_q.size() == 1);
        check("data2", out_data2, m_q[0]);
        check("last2", out_last2, m_q.size() == 1);
      end else begin
        check("last_idle", out_last, 0);
      end
      check("drop_cnt", drop_cnt, (m_drops > 65535) ? 65535 : m_drops);
      check("drop_cnt2", drop_cnt2, (m_drops > 3) ? 3 : m_drops);
      if (busy) busy_cycles++;
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic [31:0] pc);
    snap_req = 1'b1;
    pc_in    = pc;
    tick();
    snap_req = 1'b0;
    pc_in    = $urandom;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (m_active && n < limit) begin
      tick();
      n++;
    end
    check("frame_done_in_budget", m_active, 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] pat;
    for (int n = 0; n < 32; n++) regs[n] = 32'h1000 + 32'(n);

    // reset values
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // full-rate frame with known register contents
    out_ready = 1'b1;
    got.delete();
    busy_cycles = 0;
    snap(32'h0040_0000);
    wait_idle(100);
    tick();
    check("f1_words", got.size(), 20);
    check("f1_hdr", got[0], 32'hA514_0000);
    check("f1_pc", got[1], 32'h0040_0000);
    check("f1_s0", got[2], 32'h0000_1010);
    check("f1_s7", got[9], 32'h0000_1017);
    check("f1_t0", got[10], 32'h0000_1008);
    check("f1_t7", got[17], 32'h0000_100F);
    check("f1_t8", got[18], 32'h0000_1018);
    check("f1_t9", got[19], 32'h0000_1019);
    check("f1_busy_cycles", busy_cycles, 20);

    // same frame with ready pattern 1,0,0,1,...
    pat = 4'b1001;
    got.delete();
    snap(32'h0040_0000);
    for (int c = 0; c < 200 && m_active; c++) begin
      out_ready = pat[c % 4];
      tick();
    end
    check("f2_done", m_active, 0);
    out_ready = 1'b1;
    tick();
    check("f2_words", got.size(), 20);
    check("f2_hdr", got[0], 32'hA514_0001);
    check("f2_t0", got[10], 32'h0000_1008);
    check("f2_t9", got[19], 32'h0000_1019);

    // requests during a frame, one in the last-accept cycle
    do_reset();
    got.delete();
    snap(32'h0000_1234);
    for (int i = 1; i <= 20; i++) begin
      snap_req = (i == 2 || i == 5 || i == 9 || i == 14 || i == 20);
      tick();
    end
    snap_req = 1'b0;
    check("drop_busy_end", busy, 0);
    check("drop_cnt5", drop_cnt, 16'd5);
    check("drop_sat", drop_cnt2, 2'd3);
    snap(32'h0000_5678);
    wait_idle(100);
    tick();
    check("drop_words", got.size(), 40);
    check("drop_f_pc", got[1], 32'h0000_1234);
    check("drop_next_hdr", got[20], 32'hA514_0001);

    // three back-to-back frames at full rate
    do_reset();
    got.delete();
    for (int f = 0; f < 3; f++) begin
      snap(32'h0040_0000 + 32'(f * 4));
      wait_idle(100);
    end
    tick();
    check("b2b_words", got.size(), 60);
    check("b2b_hdr0", got[0], 32'hA514_0000);
    check("b2b_hdr1", got[20], 32'hA514_0001);
    check("b2b_hdr2", got[40], 32'hA514_0002);
    check("b2b_pc2", got[41], 32'h0040_0008);

    // asynchronous reset in the middle of a stalled frame
    do_reset();
    snap(32'h0040_0100);
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    tick();
    tick();
    check("mid_valid_before", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last", out_last, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    got.delete();
    snap(32'h0040_0200);
    wait_idle(100);
    tick();
    check("mid_next_hdr", got[0], 32'hA514_0000);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom % 4) != 0;
      snap_req  = ($urandom % 8) == 0;
      pc_in     = $urandom;
      if (!m_active) regs[$urandom % 32] = $urandom;
      tick();
    end
    snap_req = 1'b0;
    out_ready = 1'b1;
    wait_idle(200);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/trace_frame_streamer.md
Name: trace_frame_streamer

Overview:
- Downstream observer stage of the single-cycle CPU; synthesizable replacement for display-based register dumps.
- Each committed cycle, on request, it stalls the CPU and streams one trace frame over a valid/ready word interface.
- Frame: a header word, the PC, then 18 architectural registers in fixed order ($s0-$s7, $t0-$t7, $t8, $t9).
- Reads registers through a dedicated combinational read port on the register file.

Parameters:
- DATA_W, 32, width of PC, register data and stream words.
- DROP_W, 16, width of the saturating dropped-request counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- snap_req  in  1  one-cycle pulse from the CPU: the cycle just committed; snapshot it.
- pc_in  in  DATA_W  CPU PC_out value, sampled with snap_req.
- rd_addr  out  5  register-file debug read address.
- rd_data  in  DATA_W  combinational register-file read data for rd_addr.
- busy  out  1  stall to the CPU: no PC or register write while high.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  DATA_W  stream word.
- out_last  out  1  marks the final word (word 19) of the frame.
- drop_cnt  out  DROP_W  requests ignored while busy, saturating.

Behaviour:
- Reset is asynchronous and active-low, on one clock (clk).
  - Reset values: state IDLE, busy 0, out_valid 0, out_last 0, out_data 0, rd_addr 0, drop_cnt 0, seq 0.
  - Reset mid-frame aborts the frame immediately. No partial-frame recovery.
- FSM states:
  - IDLE: snap_req=1 at edge N loads out_data={8'hA5, 8'd20, seq[15:0]}, captures pc_in into pc_q, sets out_valid=1, enters HDR. seq increments by 1 and wraps at 2^16.
  - HDR: on accept (out_valid&out_ready), out_data<=pc_q, enter PCW.
  - PCW: on accept, out_data<=rd_data with rd_addr=ORDER[0], idx<=1, enter REGS.
  - REGS, idx<18: on accept, out_data<=rd_data at ORDER[idx], idx<=idx+1. out_last<=1 when loading ORDER[17].
  - REGS, idx==18 (last word showing): on accept, out_valid<=0, out_last<=0, enter IDLE.
- rd_addr = ORDER[idx] in REGS and ORDER[0] otherwise. It is driven from registers only (no combinational path from out_ready).
- Handshake:
  - out_data and out_last hold stable while out_valid&!out_ready.
  - out_valid never drops before acceptance.
  - One word per cycle maximum. Full-rate sink: frame occupies 20 cycles, N+1..N+20.
- busy = (state != IDLE), register-decoded. It is high in cycle N+1 so the CPU cannot write registers at edge N+1.
- Register values are read live and are valid because the CPU is stalled.
- snap_req while state!=IDLE, including the cycle the last word is accepted: ignored, drop_cnt += 1, saturates at 2^DROP_W-1. Frame and seq are unaffected.
- Back-to-back frames: earliest next accept is the cycle after return to IDLE. There is a 1-cycle minimum gap with out_valid=0.
- pc_in is ignored except in the snap_req cycle while in IDLE.

Decomposition:
- Shared package trace_pkg holds:
  - FRAME_MAGIC=8'hA5, FRAME_WORDS=20, NUM_TRACE_REGS=18.
  - ORDER constant array {16,17,18,19,20,21,22,23,8,9,10,11,12,13,14,15,24,25}.
  - State enum {IDLE,HDR,PCW,REGS}.
- One natural sub-module: trace_out_reg, the output holding register (data/last/valid) with load/accept control.
- The FSM and counters stay in the top.

Test Plan:
- Reset, then snap_req with pc_in=0x00400000, register file loaded reg[n]=0x1000+n, out_ready=1 → words A5140000, 00400000, 00001010..00001017, 00001008..0000100F, 00001018, 00001019; out_last only on word 19; busy high cycles N+1..N+20.
- Same frame, out_ready toggled 1,0,0,1,… → word sequence identical, each word held across stall cycles, no duplicates or skips, busy held until final accept.
- Three frames at full rate → headers A5140000, A5140001, A5140002; ≥1 idle cycle with out_valid=0 between frames.
- snap_req pulsed 5 times during one frame, including the last-accept cycle → drop_cnt=5, frame content unchanged, next header seq=0001.
- rst_n asserted at word 7 with out_ready=0 → out_valid, busy, out_last go 0 immediately without a clock edge; next snap_req emits header A5140000.
- Force drop_cnt path with DROP_W=2, 5 dropped requests → drop_cnt saturates at 3.
